// File: rtl/aes_dec_iter_pkg.sv
// Shared AES-128 decryption definitions: FSM states, S-box tables, round
// constants and the byte/word transforms used by the datapath.
package aes_dec_iter_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KEXP  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Round constants, indexed by round number 1..10; unused slots read as zero.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Inverse S-box, entry 0 in the top byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    return RCON[idx];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by a 4-bit constant (9, 11, 13, 14 for InvMixColumns).
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (m[0] ? a : 8'h00) ^ (m[1] ? x2 : 8'h00) ^
           (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int i = 0; i < 16; i++) begin
      o[127 - 8 * i -: 8] = inv_sbox(s[127 - 8 * i -: 8]);
    end
    return o;
  endfunction

  // Byte i sits at row i%4, column i/4; row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c - r + 4) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 8] = gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9);
      o[119 - 32 * c -: 8] = gmul(a0, 4'd9) ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13);
      o[111 - 32 * c -: 8] = gmul(a0, 4'd13) ^ gmul(a1, 4'd9) ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11);
      o[103 - 32 * c -: 8] = gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9) ^ gmul(a3, 4'd14);
    end
    return o;
  endfunction

  // rk_r -> rk_{r+1}
  function automatic logic [127:0] fwd_key_step(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3, w3;
    w3 = rk[31:0];
    n0 = rk[127:96] ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // rk_{r+1} -> rk_r; w3 must be recovered first since w0 depends on it.
  function automatic logic [127:0] rev_key_step(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n3 = rk[31:0] ^ rk[63:32];
    n2 = rk[63:32] ^ rk[95:64];
    n1 = rk[95:64] ^ rk[127:96];
    n0 = rk[127:96] ^ sub_word({n3[23:0], n3[31:24]}) ^ {rc, 24'h000000};
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/aes_dec_iter_if.sv
// Job/result handshake bundle between a producer/consumer and the engine.
interface aes_dec_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ct;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] pt;
  logic         busy;

  modport master (
    output in_valid, ct, key, out_ready,
    input  in_ready, out_valid, pt, busy
  );

  modport slave (
    input  in_valid, ct, key, out_ready,
    output in_ready, out_valid, pt, busy
  );
endinterface

// File: rtl/aes_dec_iter_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and,
// except on the last round, InvMixColumns. Purely combinational.
module aes_inv_round
  import aes_dec_iter_pkg::*;
(
  input  logic [127:0] i_st,
  input  logic [127:0] i_rk,
  input  logic         i_last,
  output logic [127:0] o_st
);
  logic [127:0] w_ark;

  assign w_ark = inv_sub_bytes(inv_shift_rows(i_st)) ^ i_rk;
  assign o_st  = i_last ? w_ark : inv_mix_columns(w_ark);
endmodule

// File: rtl/aes_dec_iter.sv
// Iterative AES-128 decryption: one inverse round per clock, round keys
// generated backwards on the fly, and a one-entry cache of the last round
// key so a repeated key skips the forward expansion pass.
module aes_dec_iter
  import aes_dec_iter_pkg::*;
#(
  parameter int NR = 10
) (
  input logic           clk,
  input logic           rst,
  aes_dec_iter_if.slave bus
);
  localparam int            RW     = $clog2(NR + 1);
  localparam logic [RW-1:0] R_ONE  = RW'(1);
  localparam logic [RW-1:0] R_LAST = RW'(NR);
  localparam logic [RW-1:0] R_PEN  = RW'(NR - 1);

  state_e        r_state, w_state_nxt;
  logic          r_in_ready, r_busy;
  logic [127:0]  r_st, w_st_nxt;
  logic [127:0]  r_rk, w_rk_nxt;
  logic [127:0]  r_key_q, w_key_q_nxt;
  logic [127:0]  r_rk10_q, w_rk10_q_nxt;
  logic [127:0]  r_cache_key, w_cache_key_nxt;
  logic          r_cache_vld, w_cache_vld_nxt;
  logic [RW-1:0] r_rnd, w_rnd_nxt;
  logic          r_align, w_align_nxt;
  logic [127:0]  r_pt, w_pt_nxt;
  logic          r_out_valid, w_out_valid_nxt;

  logic          w_hit;
  logic          w_kexp_last;
  logic [127:0]  w_fwd_rk;
  logic [127:0]  w_rev_rk;
  logic [127:0]  w_round_st;

  assign w_hit       = r_cache_vld && (bus.key == r_cache_key);
  assign w_kexp_last = !r_align && (r_rnd == R_LAST);
  assign w_fwd_rk    = fwd_key_step(r_rk, rcon(4'(r_rnd)));
  // In FINAL the counter has reached 0, so r+1 selects Rcon[1] and yields rk_0.
  assign w_rev_rk    = rev_key_step(r_rk, rcon(4'(r_rnd + R_ONE)));

  aes_inv_round u_inv_round (
    .i_st   (r_st),
    .i_rk   (w_rev_rk),
    .i_last (r_state == FINAL),
    .o_st   (w_round_st)
  );

  // State register plus the state-decoded handshake flags, registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt == IDLE);
      r_busy     <= (w_state_nxt != IDLE);
    end
  end

  // Next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = bus.in_valid ? (w_hit ? ROUND : KEXP) : IDLE;
      KEXP:    w_state_nxt = w_kexp_last ? ROUND : KEXP;
      ROUND:   w_state_nxt = (r_rnd == R_ONE) ? FINAL : ROUND;
      FINAL:   w_state_nxt = DONE;
      DONE:    w_state_nxt = bus.out_ready ? IDLE : DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath, counter, cache and result updates for the current state.
  always_comb begin
    w_st_nxt        = r_st;
    w_rk_nxt        = r_rk;
    w_key_q_nxt     = r_key_q;
    w_rk10_q_nxt    = r_rk10_q;
    w_cache_key_nxt = r_cache_key;
    w_cache_vld_nxt = r_cache_vld;
    w_rnd_nxt       = r_rnd;
    w_align_nxt     = r_align;
    w_pt_nxt        = r_pt;
    w_out_valid_nxt = r_out_valid;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_key_q_nxt = bus.key;
          if (w_hit) begin
            w_st_nxt  = bus.ct ^ r_rk10_q;
            w_rk_nxt  = r_rk10_q;
            w_rnd_nxt = R_PEN;
          end else begin
            w_st_nxt    = bus.ct;
            w_rk_nxt    = bus.key;
            w_rnd_nxt   = R_ONE;
            w_align_nxt = 1'b1;
          end
        end else begin
          w_align_nxt = 1'b0;
        end
      end
      KEXP: begin
        // The first KEXP cycle after a miss only aligns the pipeline.
        if (r_align) begin
          w_align_nxt = 1'b0;
        end else begin
          w_rk_nxt = w_fwd_rk;
          if (r_rnd == R_LAST) begin
            w_st_nxt        = r_st ^ w_fwd_rk;
            w_cache_key_nxt = r_key_q;
            w_rk10_q_nxt    = w_fwd_rk;
            w_cache_vld_nxt = 1'b1;
            w_rnd_nxt       = R_PEN;
          end else begin
            w_rnd_nxt = r_rnd + R_ONE;
          end
        end
      end
      ROUND: begin
        w_st_nxt  = w_round_st;
        w_rk_nxt  = w_rev_rk;
        w_rnd_nxt = r_rnd - R_ONE;
      end
      FINAL: begin
        w_pt_nxt        = w_round_st;
        w_out_valid_nxt = 1'b1;
      end
      DONE: begin
        if (bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
        end else begin
          w_out_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st        <= 128'h0;
      r_rk        <= 128'h0;
      r_key_q     <= 128'h0;
      r_rk10_q    <= 128'h0;
      r_cache_key <= 128'h0;
      r_cache_vld <= 1'b0;
      r_rnd       <= '0;
      r_align     <= 1'b0;
      r_pt        <= 128'h0;
      r_out_valid <= 1'b0;
    end else begin
      r_st        <= w_st_nxt;
      r_rk        <= w_rk_nxt;
      r_key_q     <= w_key_q_nxt;
      r_rk10_q    <= w_rk10_q_nxt;
      r_cache_key <= w_cache_key_nxt;
      r_cache_vld <= w_cache_vld_nxt;
      r_rnd       <= w_rnd_nxt;
      r_align     <= w_align_nxt;
      r_pt        <= w_pt_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.busy      = r_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.pt        = r_pt;
endmodule

// File: doc/aes_dec_iter.md
Name: aes_dec_iter

Overview:
Iterative AES-128 decryption engine. It performs one inverse round per clock and generates round keys in reverse, on the fly. It is the area-lean counterpart to the encryption datapath: it accepts ciphertext plus the cipher key over a valid/ready handshake and returns the plaintext over a second valid/ready handshake. A one-entry last-round-key cache removes the forward key-expansion pass when the same key is used back-to-back.

Parameters:
NR, 10, number of AES rounds. Fixed for AES-128; the parameter exists only so the round counter is sized from it.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high; clears all state
- in_valid  in  1  ct/key are valid this cycle
- in_ready  out  1  engine can accept a job (high only in IDLE)
- ct  in  128  ciphertext; byte 0 in [127:120]
- key  in  128  cipher key; same byte order as ct
- out_valid  out  1  pt is valid
- out_ready  in  1  consumer takes pt this cycle
- pt  out  128  recovered plaintext
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, pt=0, busy=0, cache_vld=0. Internal state, rk, key_q and rk10_q are cleared to 0.
- Accept: a job is accepted on a rising edge where in_valid && in_ready. At that edge, register ct into st and key into key_q.
  - If cache_vld && key==cache_key: cache hit. Set st <= ct ^ rk10_q, rk <= rk10_q, r <= 9, and go to ROUND.
  - Otherwise: cache miss. Set rk <= key, r <= 1, and go to KEXP.
- KEXP (10 cycles):
  - Each cycle, rk <= fwd_step(rk, Rcon[r]) and r++.
  - On the cycle with r==10, also apply st <= st ^ next_rk; write cache_key <= key_q, rk10_q <= next_rk, cache_vld <= 1; set r <= 9; go to ROUND.
- ROUND (9 cycles, r=9..1):
  - nrk = rev_step(rk, Rcon[r+1]), i.e. the rk_r derived from rk_{r+1}.
  - st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ nrk); rk <= nrk; r--.
  - After r==1, go to FINAL.
- FINAL (1 cycle):
  - nrk = rev_step(rk, Rcon[1]), which equals rk_0, the cipher key.
  - pt <= InvSubBytes(InvShiftRows(st)) ^ nrk; out_valid <= 1; go to DONE.
- DONE: hold pt and out_valid stable. When out_ready is high, clear out_valid and go to IDLE. pt keeps its last value.
- Latency, from the accept edge to the edge where out_valid rises:
  - cache miss: 21 cycles (10 KEXP + 9 ROUND + 1 FINAL + accept-to-KEXP alignment)
  - cache hit: 10 cycles
  - Next accept is possible in the cycle after the out_ready handshake. No overlap of jobs.
- in_valid while not IDLE: ignored. No latching, no error.
- rev_step: w0' = w0 ^ SubWord(RotWord(w3')) ^ Rcon, where w3' = w3 ^ w2, w2' = w2 ^ w1, w1' = w1 ^ w0. Compute in the order w3', w2', w1', then w0'. Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- Reset asserted mid-job: the job is abandoned immediately. No out_valid is produced and cache_vld is cleared.
- out_ready held high in IDLE has no effect.
- Simultaneous out_ready in DONE and in_valid: the job is not accepted that cycle, since in_ready is still low.

Decomposition:
- Package aes_pkg holds:
  - Rcon array
  - SBOX and INV_SBOX constant tables
  - functions sub_word, inv_sub_bytes, inv_shift_rows, inv_mix_columns, xtime, fwd_key_step, rev_key_step
  - state enum {IDLE, KEXP, ROUND, FINAL, DONE}
- One natural sub-module, aes_inv_round: purely combinational. Inputs are st, rk and a last flag (last skips InvMixColumns). The FSM, counter, cache and handshake stay in aes_dec_iter.

Test Plan:
- Reset then idle: check in_ready=1, out_valid=0, pt=0, busy=0. Assert rst for 3 cycles mid-KEXP: outputs return to reset values and no out_valid appears afterwards.
- Cache miss, known vector: key=5468617473206D79204B756E67204675, ct=29C3505F571420F6402299B31A02D73A. Requires pt=54776F204F6E65204E696E652054776F with out_valid exactly 21 cycles after accept.
- Cache hit: same key, ct from a second encryption pass. pt matches the encryption input, and out_valid rises 10 cycles after accept.
- FIPS-197 C.1, key change: key=000102030405060708090A0B0C0D0E0F, ct=69C4E0D86A7B0430D8CDB78070B4C55A. Requires pt=00112233445566778899AABBCCDDEEFF with latency 21, which confirms the cache miss.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. pt stays stable, in_ready=0, and a pulsed in_valid is ignored. Release: IDLE the next cycle.
- Back-to-back: in_valid held high with a new job queued. The second accept happens exactly 1 cycle after the first out_ready handshake, and both results are correct.
